// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback slice: sizes, ALU control
// encodings, the issue-register payload and the immediate extension helper.
package alu_pkg;

  localparam int unsigned NREGS = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned IDXW  = $clog2(NREGS);
  localparam int unsigned IMMW  = 16;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b01;

  // Issue-register contents other than the operands, which live in the
  // registers that drive the ALU inputs directly.
  typedef struct packed {
    logic            valid;
    logic            li;
    logic [IDXW-1:0] rd;
    logic [IMMW-1:0] imm;
  } issueSlot_t;

  function automatic logic [DW-1:0] zextImm(input logic [IMMW-1:0] imm);
    return DW'(imm);
  endfunction

endpackage

// File: rtl/regfile_8x32.sv
// 8x32 register file: two asynchronous read ports, one synchronous write
// port, asynchronous active-high clear to zero.
// Ports: clk, reset, rdAddrA/rdDataA, rdAddrB/rdDataB, wrEn/wrAddr/wrData.
module regfile_8x32
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [IDXW-1:0] rdAddrA,
  output logic [DW-1:0]   rdDataA,
  input  logic [IDXW-1:0] rdAddrB,
  output logic [DW-1:0]   rdDataB,
  input  logic            wrEn,
  input  logic [IDXW-1:0] wrAddr,
  input  logic [DW-1:0]   wrData
);

  logic [DW-1:0] regs [NREGS];

  // Storage; every entry, including index 0, is an ordinary register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wrEn) begin
      regs[wrAddr] <= wrData;
    end
  end

  assign rdDataA = regs[rdAddrA];
  assign rdDataB = regs[rdAddrB];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand fetch / issue and writeback stage in front of a combinational
// add/sub/xor ALU. S1 holds the issued instruction and drives the ALU; S2
// holds the completed result on a valid/ready port.
// Ports: clk, reset; instr_* (valid/ready instruction input); alu_a, alu_b,
// alu_ctrl (to ALU), alu_result (from ALU); res_valid/res_ready, res_rd,
// res_data (result output).
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            instr_li,
  input  logic [1:0]      instr_op,
  input  logic [IDXW-1:0] instr_rd,
  input  logic [IDXW-1:0] instr_rs1,
  input  logic [IDXW-1:0] instr_rs2,
  input  logic [IMMW-1:0] instr_imm,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [1:0]      alu_ctrl,
  input  logic [DW-1:0]   alu_result,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [IDXW-1:0] res_rd,
  output logic [DW-1:0]   res_data
);

  issueSlot_t      s1Q;
  logic [DW-1:0]   aluAQ;
  logic [DW-1:0]   aluBQ;
  logic [1:0]      aluCtrlQ;
  logic            resValidQ;
  logic [IDXW-1:0] resRdQ;
  logic [DW-1:0]   resDataQ;

  logic            advance;
  logic            accept;
  logic            writeback;
  logic [DW-1:0]   s1Result;
  logic [DW-1:0]   rfDataA;
  logic [DW-1:0]   rfDataB;
  logic [DW-1:0]   opA;
  logic [DW-1:0]   opB;

  // Whole pipe moves only when S2 is empty or being drained.
  assign advance     = !resValidQ || res_ready;
  assign instr_ready = advance && !reset;
  assign accept      = instr_valid && instr_ready;
  assign writeback   = s1Q.valid && advance;
  assign s1Result    = s1Q.li ? zextImm(s1Q.imm) : alu_result;

  regfile_8x32 u_rf (
    .clk     (clk),
    .reset   (reset),
    .rdAddrA (instr_rs1),
    .rdDataA (rfDataA),
    .rdAddrB (instr_rs2),
    .rdDataB (rfDataB),
    .wrEn    (writeback),
    .wrAddr  (s1Q.rd),
    .wrData  (s1Result)
  );

  // The RF write of S1 lands on the same edge as this read, so bypass it.
  always_comb begin
    opA = rfDataA;
    opB = rfDataB;
    if (writeback && (s1Q.rd == instr_rs1)) opA = s1Result;
    if (writeback && (s1Q.rd == instr_rs2)) opB = s1Result;
  end

  // S1 issue register; ALU input registers keep their value when S1 empties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Q      <= '0;
      aluAQ    <= '0;
      aluBQ    <= '0;
      aluCtrlQ <= ALU_ADD;
    end else if (advance) begin
      s1Q.valid <= accept;
      if (accept) begin
        s1Q.li   <= instr_li;
        s1Q.rd   <= instr_rd;
        s1Q.imm  <= instr_imm;
        aluAQ    <= opA;
        aluBQ    <= opB;
        aluCtrlQ <= instr_op;
      end
    end
  end

  // S2 result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resValidQ <= 1'b0;
      resRdQ    <= '0;
      resDataQ  <= '0;
    end else if (advance) begin
      resValidQ <= writeback;
      if (writeback) begin
        resRdQ   <= s1Q.rd;
        resDataQ <= s1Result;
      end
    end
  end

  assign alu_a     = aluAQ;
  assign alu_b     = aluBQ;
  assign alu_ctrl  = aluCtrlQ;
  assign res_valid = resValidQ;
  assign res_rd    = resRdQ;
  assign res_data  = resDataQ;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed, table-driven bench for alu_issue_stage with a behavioural ALU.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic        instr_li;
  logic [1:0]  instr_op;
  logic [2:0]  instr_rd;
  logic [2:0]  instr_rs1;
  logic [2:0]  instr_rs2;
  logic [15:0] instr_imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_rd;
  logic [31:0] res_data;

  alu_issue_stage dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_li    (instr_li),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .instr_imm   (instr_imm),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_rd      (res_rd),
    .res_data    (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU sitting next to the stage.
  always_comb begin
    case (alu_ctrl)
      2'b00:   alu_result = alu_a + alu_b;
      2'b10:   alu_result = alu_a - alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  typedef struct {
    logic        li;
    logic [1:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    logic [31:0] expData;
  } vec_t;

  vec_t        vecs[$];
  int          nVec = 0;
  int          nErr = 0;
  logic        monOn = 1'b0;
  int          wrCount = 0;
  logic [2:0]  gotRd[$];
  logic [31:0] gotData[$];

  // Records result handshakes and RF writes during the backpressure burst.
  always @(posedge clk) begin
    if (monOn && res_valid && res_ready) begin
      gotRd.push_back(res_rd);
      gotData.push_back(res_data);
    end
    if (monOn && dut.writeback) wrCount++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic addVec(input logic li, input logic [1:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [15:0] imm, input logic [31:0] expData);
    vec_t v;
    v.li = li; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.expData = expData;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic li, input logic [1:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic [15:0] imm);
    instr_valid = 1'b1;
    instr_li = li; instr_op = op; instr_rd = rd;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
  endtask

  // Back-to-back issue with res_ready high; result of vector k is seen two
  // falling edges after it is driven.
  task automatic runVectors(input int first, input int cnt);
    for (int i = 0; i < cnt + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        vec_t v;
        v = vecs[first + i - 2];
        chk($sformatf("v%0d.res_valid", first + i - 2), 32'(res_valid), 32'd1);
        chk($sformatf("v%0d.res_rd", first + i - 2), 32'(res_rd), 32'(v.rd));
        chk($sformatf("v%0d.res_data", first + i - 2), res_data, v.expData);
      end
      if (i < cnt) begin
        vec_t v;
        v = vecs[first + i];
        chk($sformatf("v%0d.instr_ready", first + i), 32'(instr_ready), 32'd1);
        drive(v.li, v.op, v.rd, v.rs1, v.rs2, v.imm);
      end else begin
        instr_valid = 1'b0;
      end
    end
  endtask

  initial begin
    // li, op, rd, rs1, rs2, imm, expected res_data
    addVec(1, 2'b00, 1, 0, 0, 16'd12,   32'd12);
    addVec(1, 2'b00, 2, 0, 0, 16'd4,    32'd4);
    addVec(0, 2'b00, 3, 1, 2, 16'd0,    32'd16);
    addVec(1, 2'b00, 0, 0, 0, 16'd0,    32'd0);
    addVec(0, 2'b00, 5, 3, 0, 16'd0,    32'd16);
    addVec(1, 2'b00, 1, 0, 0, 16'd20,   32'd20);
    addVec(1, 2'b00, 2, 0, 0, 16'd14,   32'd14);
    addVec(0, 2'b10, 3, 1, 2, 16'd0,    32'd6);
    addVec(0, 2'b10, 4, 2, 1, 16'd0,    32'hFFFF_FFFA);
    addVec(1, 2'b00, 1, 0, 0, 16'hF0F0, 32'h0000_F0F0);
    addVec(1, 2'b00, 2, 0, 0, 16'h0FF0, 32'h0000_0FF0);
    addVec(0, 2'b01, 6, 1, 2, 16'd0,    32'h0000_FF00);
    addVec(0, 2'b11, 7, 1, 2, 16'd0,    32'h0000_FF00);
    addVec(0, 2'b00, 6, 6, 7, 16'd0,    32'h0001_FE00);
    addVec(1, 2'b00, 2, 0, 0, 16'hFFFF, 32'h0000_FFFF);
    addVec(0, 2'b00, 2, 2, 2, 16'd0,    32'h0001_FFFE);
    addVec(0, 2'b00, 2, 2, 2, 16'd0,    32'h0003_FFFC);
    addVec(1, 2'b00, 1, 0, 0, 16'd1,    32'd1);
    addVec(0, 2'b10, 3, 0, 1, 16'd0,    32'hFFFF_FFFF);
    addVec(0, 2'b00, 3, 3, 1, 16'd0,    32'd0);
    // Read-back of every register after a reset: rX + rX must be 0.
    for (int r = 0; r < 8; r++) addVec(0, 2'b00, 3'(r), 3'(r), 3'(r), 16'd0, 32'd0);

    reset = 1'b1;
    instr_valid = 1'b0;
    drive(0, 2'b00, 0, 0, 0, 16'd0);
    instr_valid = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.instr_ready_in_reset", 32'(instr_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst.res_valid", 32'(res_valid), 32'd0);
    chk("rst.res_rd", 32'(res_rd), 32'd0);
    chk("rst.res_data", res_data, 32'd0);
    chk("rst.alu_a", alu_a, 32'd0);
    chk("rst.alu_b", alu_b, 32'd0);
    chk("rst.alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst.instr_ready", 32'(instr_ready), 32'd1);

    runVectors(0, 20);

    // Backpressure: A=li r1,5  B=li r2,7  C=add r3,r1,r2  D=sub r4,r3,r1
    @(negedge clk);
    monOn = 1'b1;
    res_ready = 1'b1;
    drive(1, 2'b00, 1, 0, 0, 16'd5);
    @(negedge clk);
    drive(1, 2'b00, 2, 0, 0, 16'd7);
    @(negedge clk);
    drive(0, 2'b00, 3, 1, 2, 16'd0);
    res_ready = 1'b0;
    #1;
    chk("bp.res_valid", 32'(res_valid), 32'd1);
    chk("bp.instr_ready_low", 32'(instr_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp.hold%0d.instr_ready", c), 32'(instr_ready), 32'd0);
      chk($sformatf("bp.hold%0d.res_valid", c), 32'(res_valid), 32'd1);
      chk($sformatf("bp.hold%0d.res_rd", c), 32'(res_rd), 32'd1);
      chk($sformatf("bp.hold%0d.res_data", c), res_data, 32'd5);
      if (c == 2) res_ready = 1'b1;
    end
    #1;
    chk("bp.instr_ready_back", 32'(instr_ready), 32'd1);
    @(negedge clk);
    drive(0, 2'b10, 4, 3, 1, 16'd0);
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    monOn = 1'b0;
    chk("bp.count", 32'(gotRd.size()), 32'd4);
    chk("bp.rf_writes", 32'(wrCount), 32'd4);
    begin
      logic [2:0]  expRd[4];
      logic [31:0] expData[4];
      expRd = '{3'd1, 3'd2, 3'd3, 3'd4};
      expData = '{32'd5, 32'd7, 32'd12, 32'd7};
      for (int k = 0; k < 4; k++) begin
        if (k < gotRd.size()) begin
          chk($sformatf("bp.out%0d.rd", k), 32'(gotRd[k]), 32'(expRd[k]));
          chk($sformatf("bp.out%0d.data", k), gotData[k], expData[k]);
        end
      end
    end

    // Reset mid-stream with S1 and S2 both valid.
    @(negedge clk);
    drive(1, 2'b00, 5, 0, 0, 16'h1234);
    @(negedge clk);
    drive(1, 2'b00, 6, 0, 0, 16'h5678);
    @(posedge clk);
    #2;
    chk("mid.res_valid_before", 32'(res_valid), 32'd1);
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid.res_valid_async", 32'(res_valid), 32'd0);
    chk("mid.res_data_async", res_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid.instr_ready", 32'(instr_ready), 32'd1);
    chk("mid.res_valid", 32'(res_valid), 32'd0);

    runVectors(20, 8);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand-fetch/issue and writeback stage that sits directly upstream of the combinational ALU (add/sub/xor) and feeds its InputA/InputB/ALUControl. It accepts register-to-register instructions over a valid/ready handshake and reads operands from an internal 8×32 register file, forwarding from the in-flight instruction where needed. It drives the ALU and writes the ALU result back into the register file. Every completed instruction is presented once on a backpressurable result port.

## Interface
- NREGS, 8, number of architectural registers; index width is log2(NREGS) = 3.
- DW, 32, datapath width; must match the ALU width.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  instruction accepted on the edge where valid && ready.
- instr_li  input  1  1 = load-immediate (bypasses ALU); 0 = ALU op.
- instr_op  input  2  ALU control: 00 add, 10 sub, 01 xor, 11 treated as xor.
- instr_rd  input  3  destination register.
- instr_rs1  input  3  source A (ignored when instr_li).
- instr_rs2  input  3  source B (ignored when instr_li).
- instr_imm  input  16  immediate, zero-extended to DW (used only when instr_li).
- alu_a  output  32  to ALU InputA.
- alu_b  output  32  to ALU InputB.
- alu_ctrl  output  2  to ALU ALUControl.
- alu_result  input  32  from ALU Output; combinational in the same cycle.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_rd  output  3  destination of the presented result.
- res_data  output  32  value written to res_rd.

## Operation
- Two registered stages:
  - S1 (issue register): valid, li, op, rd, opA, opB, imm.
  - S2 (result register): res_valid, res_rd, res_data.
- advance = !res_valid || res_ready.
- instr_ready = advance (combinational). When S2 is held, both S1 and the input stall.
- Issue: on accept, S1 captures the fields and operand values.
  - opA = RF[rs1] and opB = RF[rs2], except when S1 is valid, advancing on the same edge, and S1.rd matches the source index. In that case the operand takes S1's result (forwarding). This happens with no stall and no bubble.
- Execute: alu_a = S1.opA, alu_b = S1.opB, alu_ctrl = S1.op while S1 is valid.
  - S1 result = zero-extended imm when li, otherwise alu_result.
  - alu_* hold their last value while S1 is invalid.
- Writeback: on the edge where S1 is valid and advance is true:
  - RF[S1.rd] takes S1's result, and S2 loads {S1.rd, result} with res_valid = 1.
  - Each instruction writes the RF exactly once.
- Output: a result stays stable while res_valid && !res_ready.
  - If no new S1 result arrives, res_valid clears on the edge where it is accepted.
  - If a new S1 result arrives on that same edge, S2 reloads back-to-back.
- Arithmetic: modulo 2^DW. Subtraction wraps (two's complement). No carry or overflow is reported.
- All registers, including index 0, are ordinary writable registers.

## Timing
- Reset values: RF all 0; S1 invalid; res_valid 0; res_rd 0; res_data 0; alu_a/alu_b 0; alu_ctrl 00.
- instr_ready is 1 coming out of reset.
- Latency:
  - Accept at edge N → ALU driven during cycle N..N+1.
  - RF write and res_valid at edge N+1, with res_ready high.
- Throughput: one instruction per cycle when res_ready stays high.
- Same-edge write and read of the same register: the forwarded value is used, never the stale RF value.
- Reset mid-operation: the in-flight S1 instruction is discarded without an RF write. res_valid drops asynchronously.
- No instruction is accepted while reset is high.

## Structure
- Shared package alu_pkg:
  - ALU_ADD = 2'b00, ALU_SUB = 2'b10, ALU_XOR = 2'b01.
  - NREGS and DW defaults.
  - Register-index width.
- One sub-module, regfile_8x32:
  - 2 asynchronous read ports.
  - 1 synchronous write port.
  - Asynchronous active-high reset to zero.
- Forwarding and handshake logic live in alu_issue_stage. The ALU is instantiated alongside it, not inside it.

## Test plan
- Reset:
  - Stimulus: assert reset mid-stream with S1 valid.
  - Required response: res_valid = 0 immediately, instr_ready = 1 after release, and a later read of every register gives 0.
- Back-to-back forwarding:
  - Stimulus: li r1,12; li r2,4; add r3,r1,r2 on consecutive cycles.
  - Required response: res_data 12, 4, 16 on three consecutive cycles, and RF[r3] = 16.
- Subtraction:
  - Stimulus: li r1,20; li r2,14; sub r3,r1,r2; sub r4,r2,r1.
  - Required response: 6, then 0xFFFFFFFA.
- XOR and op 11:
  - Stimulus: li r1,0xF0F0; li r2,0x0FF0; op 01 and op 11 on r1,r2.
  - Required response: 0x0000FF00 both times.
- Backpressure:
  - Stimulus: res_ready low for 3 cycles during a 4-instruction burst.
  - Required response: instr_ready low, res_data/res_rd held, and each result appears exactly once in order with a single RF write each.
